// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, parity encoding and parity helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ (odd ? PAR_ODD : PAR_EVEN);
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding words waiting for transmission
module uart_tx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  // storage is not reset; pointers and count alone define what is valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  // pointer and occupancy bookkeeping; power-of-2 depth makes pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: buffered UART transmitter with runtime baud, parity and stop-bit config
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic [BAUD_W-1:0] baud,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic              TX,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [CW-1:0]     fifo_cnt
);
  uart_tx_state_t state_q;
  logic [DATA_W-1:0] sh_q, fifo_dout;
  logic [BAUD_W-1:0] baud_q, cnt_q;
  logic [3:0] bit_q;
  logic par_en_q, par_q, two_q, tx_q, done_q, full, empty, tick, stop_end, load;
  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid), .pop(load), .din(tx_data),
    .dout(fifo_dout), .full(full), .empty(empty), .count(fifo_cnt)
  );
  assign tx_ready = !full;
  assign TX = tx_q;
  assign tx_done = done_q;
  assign tx_busy = state_q != IDLE;
  // bit boundary, last stop bit, and frame start (from idle or straight after a stop bit)
  always_comb begin
    tick = cnt_q == baud_q;
    stop_end = state_q == STOP && tick && bit_q == 4'(two_q);
    load = !empty && (state_q == IDLE || stop_end);
  end
  // frame sequencer: config is latched at frame start so mid-frame changes are ignored
  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      baud_q <= '0;
      par_en_q <= 1'b0;
      par_q <= 1'b0;
      two_q <= 1'b0;
    end else if (load) begin
      state_q <= START;
      tx_q <= 1'b0;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= fifo_dout;
      baud_q <= baud;
      par_en_q <= parity_en;
      par_q <= calc_parity(9'(fifo_dout), parity_odd);
      two_q <= two_stop;
      done_q <= stop_end;
    end else if (state_q != IDLE) begin
      cnt_q <= tick ? '0 : cnt_q + BAUD_W'(1);
      if (tick) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            tx_q <= sh_q[0];
            bit_q <= '0;
          end
          DATA: begin
            if (bit_q == 4'(DATA_W - 1)) begin
              state_q <= par_en_q ? PARITY : STOP;
              tx_q <= par_en_q ? par_q : 1'b1;
              bit_q <= '0;
            end else begin
              sh_q <= sh_q >> 1;
              tx_q <= sh_q[1];
              bit_q <= bit_q + 4'd1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q <= 1'b1;
            bit_q <= '0;
          end
          STOP: begin
            tx_q <= 1'b1;
            bit_q <= bit_q + 4'd1;
            if (stop_end) begin
              state_q <= IDLE;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: scoreboard bench comparing the serial waveform against a frame model
module tb_uart_tx_fifo_cfg;
  typedef struct {
    logic [7:0] d;
    int b;
    bit pe;
    bit po;
    bit ts;
  } item_t;
  typedef bit bq_t[$];

  logic clk = 0, rst_n = 0, tx_valid = 0, parity_en = 0, parity_odd = 0, two_stop = 0;
  logic [7:0] tx_data = '0;
  logic [15:0] baud = '0;
  logic tx_ready, TX, tx_busy, tx_done;
  logic [2:0] fifo_cnt;
  int n_chk = 0, n_pass = 0, cyc = 0;
  item_t exp_q[$];
  int done_t[$];
  bq_t samp;
  bit in_fr = 0;

  uart_tx_fifo_cfg dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .baud(baud), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .TX(TX), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // reference: the line level for every clock of a frame, built from the frame rules
  function automatic bq_t frame(item_t it);
    bq_t bits, w;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(it.d[i]);
    if (it.pe) bits.push_back((^it.d) ^ it.po);
    bits.push_back(1'b1);
    if (it.ts) bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r <= it.b; r++) w.push_back(bits[k]);
    return w;
  endfunction

  always @(negedge clk) begin : mon
    item_t it;
    bq_t w;
    int bad;
    if (!rst_n) begin
      in_fr = 0;
      samp.delete();
    end else begin
      if (tx_done) begin
        done_t.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected tx_done", 0, 1, 0);
        else begin
          it = exp_q.pop_front();
          w = frame(it);
          bad = (samp.size() == w.size()) ? -1 : 0;
          for (int i = 0; i < w.size() && i < samp.size() && bad < 0; i++)
            if (samp[i] != w[i]) bad = i;
          chk($sformatf("frame %02h waveform len/first-diff %0d", it.d, bad), bad < 0,
              samp.size(), w.size());
        end
        in_fr = 0;
      end
      if (!in_fr && TX == 1'b0) begin
        in_fr = 1;
        samp.delete();
      end
      if (in_fr) samp.push_back(TX);
      chk("tx_busy", tx_busy == in_fr, tx_busy, in_fr);
      chk("fifo_cnt bound", fifo_cnt <= 4, fifo_cnt, 4);
      chk("tx_ready vs full", tx_ready == (fifo_cnt != 4), tx_ready, fifo_cnt != 4);
    end
  end

  task automatic setcfg(input int b, input bit pe, input bit po, input bit ts);
    baud = 16'(b);
    parity_en = pe;
    parity_odd = po;
    two_stop = ts;
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    tx_valid = 1;
    tx_data = d;
    while (!tx_ready && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept within bound", tx_ready, t, 20000);
    if (tx_ready) exp_q.push_back('{d: d, b: int'(baud), pe: parity_en, po: parity_odd, ts: two_stop});
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((tx_busy || fifo_cnt != 0 || exp_q.size() != 0) && t < 50000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain within bound", t < 50000, t, 50000);
  endtask

  initial begin
    int c0, nd, nlow;
    repeat (3) @(posedge clk);
    #1;
    chk("reset TX", TX == 1, TX, 1);
    chk("reset tx_busy", tx_busy == 0, tx_busy, 0);
    chk("reset tx_done", tx_done == 0, tx_done, 0);
    chk("reset fifo_cnt", fifo_cnt == 0, fifo_cnt, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("tx_ready after reset", tx_ready == 1, tx_ready, 1);

    setcfg(3, 0, 0, 0);
    done_t.delete();
    c0 = cyc;
    send(8'hA5);
    tx_valid = 0;
    wait_idle();
    chk("8N1 done count", done_t.size() == 1, done_t.size(), 1);
    if (done_t.size() > 0) chk("8N1 done at 40", done_t[0] - (c0 + 2) == 40, done_t[0] - (c0 + 2), 40);

    setcfg(3, 1, 0, 0); send(8'hA5); tx_valid = 0; wait_idle();
    setcfg(3, 1, 1, 0); send(8'hA5); tx_valid = 0; wait_idle();
    setcfg(3, 1, 0, 1);
    done_t.delete();
    c0 = cyc;
    send(8'hA5);
    tx_valid = 0;
    wait_idle();
    if (done_t.size() > 0) chk("12-bit frame length", done_t[0] - (c0 + 2) == 48, done_t[0] - (c0 + 2), 48);

    setcfg(0, 0, 0, 0);
    done_t.delete();
    send(8'h01);
    send(8'hFF);
    tx_valid = 0;
    wait_idle();
    chk("b2b done count", done_t.size() == 2, done_t.size(), 2);
    if (done_t.size() == 2) chk("b2b done spacing", done_t[1] - done_t[0] == 10, done_t[1] - done_t[0], 10);

    setcfg(3, 0, 0, 0);
    c0 = cyc;
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
    chk("5 pushes no stall", cyc - c0 == 5, cyc - c0, 5);
    tx_valid = 0;
    wait_idle();

    setcfg(50, 0, 0, 0);
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
    chk("stall tx_ready low", tx_ready == 0, tx_ready, 0);
    chk("stall fifo_cnt", fifo_cnt == 4, fifo_cnt, 4);
    c0 = cyc;
    send(8'h25);
    chk("6th push held off", cyc - c0 > 100, cyc - c0, 101);
    tx_valid = 0;
    wait_idle();

    setcfg(2, 0, 0, 0);
    send(8'h96);
    tx_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("mid-frame busy", tx_busy == 1, tx_busy, 1);
    setcfg(4, 1, 1, 1);
    send(8'h3B);
    tx_valid = 0;
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        tx_valid = 0;
        wait_idle();
        setcfg($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tx_valid = 0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    tx_valid = 0;
    wait_idle();

    setcfg(3, 0, 0, 0);
    send(8'h3C);
    send(8'h55);
    send(8'h66);
    tx_valid = 0;
    repeat (12) begin @(posedge clk); #1; end
    chk("pre-reset busy", tx_busy == 1, tx_busy, 1);
    rst_n = 0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort TX", TX == 1, TX, 1);
    chk("abort fifo_cnt", fifo_cnt == 0, fifo_cnt, 0);
    chk("abort tx_busy", tx_busy == 0, tx_busy, 0);
    rst_n = 1;
    nd = 0;
    nlow = 0;
    repeat (50) begin
      nd += int'(tx_done);
      nlow += int'(!TX);
      @(posedge clk); #1;
    end
    chk("no tx_done after abort", nd == 0, nd, 0);
    chk("line idle after abort", nlow == 0, nlow, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter: configurable data width, runtime baud divisor, optional even/odd parity, and 1 or 2 stop bits. A small input FIFO with a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the command/response logic and the TX pin, replacing the single-byte trmt/tx_done transmitter for multi-byte responses.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
BAUD_W, 16, width of the baud divisor input.
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_W  word to send; captured when tx_valid & tx_ready
tx_ready  output  1  FIFO can accept a word (not full)
baud  input  BAUD_W  bit period = baud+1 clocks
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity; ignored when parity_en=0
two_stop  input  1  1 = two stop bits
TX  output  1  serial line; idles high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit
fifo_cnt  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset: sampled only on posedge clk while rst_n=0. Reset values: TX=1, tx_busy=0, tx_done=0, fifo_cnt=0, tx_ready=1 (from the cycle after reset is released), FSM=IDLE, FIFO pointers=0.
- Reset mid-frame: frame is aborted, FIFO contents are discarded, TX=1 on the next edge.
- FIFO: push when tx_valid & tx_ready. tx_ready = (fifo_cnt != FIFO_DEPTH); it is low when full, even if a pop occurs in the same cycle. Push and pop in the same cycle leave fifo_cnt unchanged. Pointers wrap modulo FIFO_DEPTH. A push while full is ignored and the data is not stored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: when fifo_cnt != 0. On that edge: pop the FIFO; load the shift register; latch baud, parity_en, parity_odd and two_stop. Config changes mid-frame have no effect.
- Latency: handshake in cycle N into an empty FIFO in IDLE → fifo_cnt=1 in cycle N+1 → pop on the N+1 edge → TX=0 from cycle N+2.
- Bit timing: the baud counter clears on every frame start and every bit boundary, then counts 0..baud_latched. The bit advances when count == baud_latched, so each bit lasts exactly baud+1 clocks. baud=0 gives 1 clock per bit (legal).
- START: TX=0 for one bit period, then DATA.
- DATA: DATA_W bits, LSB first; bit counter 0..DATA_W-1. After the last bit, go to PARITY if parity_en is latched, else STOP.
- PARITY: one bit period. Value is XOR of the data bits when even; its inverse when odd.
- STOP: TX=1 for 1 or 2 bit periods, per latched two_stop.
- End of last stop bit: tx_done=1 for exactly that cycle's edge (one cycle high).
  - FIFO non-empty: go directly to START; pop and relatch on that same edge; no extra idle bit.
  - FIFO empty: go to IDLE.
- tx_busy = (state != IDLE).
- TX is a registered output, glitch-free.
- Frame length = (1 + DATA_W + parity_en + 1 + two_stop) × (baud+1) clocks.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparams for parity mode encoding
  - function calc_parity(data, odd)
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by width and depth. Ports: push, pop, din, dout, full, empty, count. dout is valid while not empty.
- The top level holds the FSM, baud counter, bit counter, shift register and config latch.

Test Plan:
- 8N1, baud=3, send 0xA5 → TX low 4 clocks, then 1,0,1,0,0,1,0,1 (4 clocks each), high 4 clocks; tx_done pulse at clock 40 after the frame starts; tx_busy drops on the same edge.
- parity_en=1, parity_odd=0, 0xA5 → parity bit 0; parity_odd=1 → parity bit 1. two_stop=1 → 2 stop periods; total frame 12×(baud+1) clocks.
- Push 5 words with FIFO_DEPTH=4 while IDLE, tx_valid held high → first pop frees one slot, so all 5 words are accepted across the cycles. Repeat the push of 5 with the TX side stalled (large baud) → tx_ready=0 after 4 stored words plus 1 in flight; the 6th push is held off; fifo_cnt never exceeds 4.
- Back-to-back 0x01, 0xFF at baud=0 → 20 contiguous TX bits with no idle bit between frames; two tx_done pulses 10 clocks apart.
- Change baud/parity_en mid-frame → current frame uses the old values; the next frame uses the new values.
- Assert rst_n=0 for one cycle during DATA → TX=1, fifo_cnt=0, tx_busy=0 on the next edge; no tx_done pulse.
